// File: rtl/four_input_nor_gate_a_reg.sv
// four_input_nor_gate_a_reg: 4-input NOR cell with a registered copy of e,
// a 16-entry input-pattern coverage map and a saturating count of e-high cycles.
module four_input_nor_gate_a_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             clr_cov,
   output logic             e,
   output logic             e_q,
   output logic [15:0]      cov_map,
   output logic             cov_all,
   output logic [CNT_W-1:0] true_cnt
);
   logic [15:0]      cov_q, cov_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign e = ~(a | b | c | d);
   // clear wins over recording the current pattern
   always_comb begin
      cov_d = clr_cov ? 16'h0000 : cov_q | (16'h0001 << {a, b, c, d});
      cnt_d = clr_cov ? '0 : (e && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         e_q   <= 1'b0;
         cov_q <= 16'h0000;
         cnt_q <= '0;
      end else begin
         e_q   <= e;
         cov_q <= cov_d;
         cnt_q <= cnt_d;
      end
   assign cov_map  = cov_q;
   assign cov_all  = &cov_q;
   assign true_cnt = cnt_q;
endmodule

// File: tb/tb_four_input_nor_gate_a_reg.sv
// tb_four_input_nor_gate_a_reg: checks the NOR cell against a set/counter reference
// model, using a truth-table sweep, directed corner cases and random patterns.
module tb_four_input_nor_gate_a_reg;
   logic        clk = 1'b0;
   logic        rst_n, a, b, c, d, clr_cov;
   logic        e, e_q, cov_all, e2, e_q2, cov_all2;
   logic [15:0] cov_map, cov_map2;
   logic [15:0] true_cnt;
   logic [1:0]  true_cnt2;
   int          errors = 0, checks = 0;
   bit          seen [16];
   int          cnt_m, cnt2_m;
   logic        eq_m;
   typedef struct packed {logic [3:0] pat; logic exp_e;} vec_t;
   vec_t        vt [16];
   int          sat_exp [6] = '{1, 2, 3, 3, 3, 3};

   four_input_nor_gate_a_reg dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr_cov(clr_cov),
      .e(e), .e_q(e_q), .cov_map(cov_map), .cov_all(cov_all), .true_cnt(true_cnt));
   four_input_nor_gate_a_reg #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr_cov(clr_cov),
      .e(e2), .e_q(e_q2), .cov_map(cov_map2), .cov_all(cov_all2), .true_cnt(true_cnt2));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (seen[i]) seen[i] = 1'b0;
      cnt_m = 0; cnt2_m = 0; eq_m = 1'b0;
   endtask

   function automatic logic [15:0] exp_cov();
      logic [15:0] m = '0;
      foreach (seen[i]) m[i] = seen[i];
      return m;
   endfunction

   task automatic check_regs();
      chk("e_q", e_q, eq_m);
      chk("cov_map", cov_map, exp_cov());
      chk("cov_all", cov_all, exp_cov() == 16'hFFFF);
      chk("true_cnt", true_cnt, cnt_m);
      chk("true_cnt_w2", true_cnt2, cnt2_m);
   endtask

   // apply one pattern for one clock, update the model at the edge, compare after
   task automatic step(input logic [3:0] p, input logic cl);
      {a, b, c, d} = p;
      clr_cov = cl;
      #1 chk("e", e, p == 4'h0);
      @(posedge clk);
      eq_m = (p == 4'h0);
      if (cl) begin
         foreach (seen[i]) seen[i] = 1'b0;
         cnt_m = 0; cnt2_m = 0;
      end else begin
         seen[p] = 1'b1;
         if (p == 4'h0) begin
            cnt_m  = (cnt_m  < 65535) ? cnt_m  + 1 : cnt_m;
            cnt2_m = (cnt2_m < 3)     ? cnt2_m + 1 : cnt2_m;
         end
      end
      @(negedge clk);
      check_regs();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) vt[i] = '{pat: 4'(i), exp_e: (i == 0)};
      rst_n = 1'b0; clr_cov = 1'b0; {a, b, c, d} = 4'h0;
      model_reset();
      // unclocked sweep: d every 10ns, c 20ns, b 40ns, a 80ns
      for (int i = 0; i < 100; i++) begin
         {a, b, c, d} = 4'(i % 16);
         #5 chk("sweep_e", e, (i % 16) == 0);
         #5;
      end
      {a, b, c, d} = 4'h0;
      #1 chk("rst_e", e, 1'b1);
      check_regs();
      @(negedge clk);
      rst_n = 1'b1;
      step(4'h0, 1'b0);
      chk("first_cov", cov_map, 16'h0001);
      chk("first_cnt", true_cnt, 1);
      // clocked truth-table sweep from a cleared state
      step(4'hF, 1'b1);
      for (int i = 0; i < 16; i++) begin
         step(vt[i].pat, 1'b0);
         chk("tbl_e_q", e_q, vt[i].exp_e);
      end
      chk("sweep_cov", cov_map, 16'hFFFF);
      chk("sweep_all", cov_all, 1'b1);
      chk("sweep_cnt", true_cnt, 1);
      // clear priority with full coverage and an all-zero pattern
      step(4'h0, 1'b1);
      chk("clr_cov", cov_map, 16'h0000);
      chk("clr_cnt", true_cnt, 0);
      chk("clr_all", cov_all, 1'b0);
      chk("clr_e_q", e_q, 1'b1);
      // saturation of the 2-bit counter
      for (int i = 0; i < 6; i++) begin
         step(4'h0, 1'b0);
         chk("sat_cnt", true_cnt2, sat_exp[i]);
      end
      // random patterns with occasional clears
      for (int i = 0; i < 300; i++)
         step(4'($urandom_range(15)), ($urandom_range(15) == 0));
      // asynchronous reset between edges
      step(4'h3, 1'b0);
      step(4'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk("arst_e_q", e_q, 1'b0);
      chk("arst_cov", cov_map, 16'h0000);
      chk("arst_all", cov_all, 1'b0);
      chk("arst_cnt", true_cnt, 0);
      chk("arst_e", e, 1'b1);
      {a, b, c, d} = 4'h8;
      #1 chk("arst_e_follow", e, 1'b0);
      model_reset();
      @(negedge clk);
      check_regs();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step(4'($urandom_range(15)), 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
